// File: rtl/stuck_bist_pkg.sv
// Shared definitions for the stuck-at BIST engine.
//   state_e                 : engine FSM states (IDLE, RUN, FAIL)
//   npat()                  : number of patterns in one sweep for a given width
//   PAT_ZEROS / PAT_ONES    : indices of the two solid patterns
//   PAT_WALK1_BASE          : first walking-1 index
//   walk0_base()            : first walking-0 index for a given width
package stuck_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam int PAT_ZEROS      = 0;
  localparam int PAT_ONES       = 1;
  localparam int PAT_WALK1_BASE = 2;

  // all-zeros, all-ones, one walking-1 per bit, one walking-0 per bit
  function automatic int npat(input int width);
    return 2 + 2 * width;
  endfunction

  function automatic int walk0_base(input int width);
    return PAT_WALK1_BASE + width;
  endfunction

endpackage

// File: rtl/stuck_at_bist_if.sv
// Bus between the BIST engine and its surroundings (CUT + status consumer).
// Parameter WIDTH : CUT bus width.
// Signals:
//   start     : request a test run (sampled on rising clk edge)
//   test_out  : pattern driven to the CUT
//   test_in   : CUT read-back, synchronous to clk
//   busy      : run in progress
//   done      : one-cycle end-of-run pulse (pass or fail)
//   fault     : sticky stuck-at flag
//   fault_bit : lowest failing bit index
//   fault_val : stuck polarity (value read back on the failing bit)
// Handshake: start is a level sampled each rising edge; it is accepted only
// while busy=0, there is no ready/ack and no queuing of a start seen while busy.
// Modports: slave = the engine, master = the environment.
interface stuck_at_bist_if #(
  parameter int WIDTH = 8
) ();
  localparam int BW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] test_out;
  logic [WIDTH-1:0] test_in;
  logic             busy;
  logic             done;
  logic             fault;
  logic [BW-1:0]    fault_bit;
  logic             fault_val;

  modport slave (
    input  start, test_in,
    output test_out, busy, done, fault, fault_bit, fault_val
  );

  modport master (
    output start, test_in,
    input  test_out, busy, done, fault, fault_bit, fault_val
  );
endinterface

// File: rtl/stuck_bist_patgen.sv
// Combinational pattern generator: maps a sweep index to the CUT pattern.
//   idx_i : pattern index, 0 .. npat(WIDTH)-1
//   pat_o : pattern (zeros, ones, walking-1, walking-0); out-of-range -> 0
import stuck_bist_pkg::*;

module stuck_bist_patgen #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(npat(WIDTH))
) (
  input  logic [IW-1:0]    idx_i,
  output logic [WIDTH-1:0] pat_o
);
  localparam int NP = npat(WIDTH);
  localparam int W0 = walk0_base(WIDTH);

  logic [IW-1:0] off;

  always_comb begin
    off   = '0;
    pat_o = '0;
    if (idx_i == IW'(PAT_ONES)) begin
      pat_o = '1;
    end else if (idx_i >= IW'(PAT_WALK1_BASE) && idx_i < IW'(W0)) begin
      off   = idx_i - IW'(PAT_WALK1_BASE);
      pat_o = WIDTH'(1) << off;
    end else if (idx_i >= IW'(W0) && idx_i < IW'(NP)) begin
      off   = idx_i - IW'(W0);
      pat_o = ~(WIDTH'(1) << off);
    end
  end
endmodule

// File: rtl/stuck_at_bist.sv
// Stuck-at BIST engine. Sweeps a fixed pattern set over the CUT bus, holds
// each pattern SETTLE+1 cycles, compares the read-back on the last cycle and
// latches the lowest mismatching bit and its polarity on the first failure.
// Parameters: WIDTH (bus width, >=2), SETTLE (extra hold cycles, >=1).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : stuck_at_bist_if.slave (start/test_out/test_in/status)
//   dbg_state_o  : current FSM state
// Build option: STUCK_BIST_CONT_EN -- when defined, a passing sweep restarts
// immediately at pattern 0 (continuous monitoring) instead of going idle.
import stuck_bist_pkg::*;

module stuck_at_bist #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  stuck_at_bist_if.slave        bus,
  output state_e                dbg_state_o
);
  localparam int NPAT = npat(WIDTH);
  localparam int PW   = $clog2(NPAT);
  localparam int BW   = $clog2(WIDTH);
  localparam int CW   = $clog2(SETTLE + 1);

  state_e           state_q;
  logic [PW-1:0]    p_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] test_out_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;
  logic [BW-1:0]    fault_bit_q;
  logic             fault_val_q;

  logic [PW-1:0]    pat_idx_d;
  logic [WIDTH-1:0] pat_nxt;
  logic [WIDTH-1:0] mism;
  logic [BW-1:0]    low_idx;
  logic             at_cmp;
  logic             last_pat;

  assign mism     = bus.test_in ^ test_out_q;
  assign at_cmp   = (cnt_q == CW'(SETTLE));
  assign last_pat = (p_q == PW'(NPAT - 1));

  // Index of the pattern to load on this edge. Every load except an
  // in-sweep advance starts the sweep, hence the default of 0.
  always_comb begin
    pat_idx_d = '0;
    if (state_q == ST_RUN && at_cmp && !last_pat) begin
      pat_idx_d = p_q + PW'(1);
    end
  end

  stuck_bist_patgen #(
    .WIDTH (WIDTH),
    .IW    (PW)
  ) u_patgen (
    .idx_i (pat_idx_d),
    .pat_o (pat_nxt)
  );

  // Lowest-set-bit priority encoder: scanning high to low lets the lowest
  // mismatching index win.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mism[i]) low_idx = BW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      cnt_q       <= '0;
      test_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fault_bit_q <= '0;
      fault_val_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_RUN;
            p_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            test_out_q <= pat_nxt;
          end
        end
        ST_RUN: begin
          if (!at_cmp) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (|mism) begin
            state_q     <= ST_FAIL;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            test_out_q  <= '0;
            fault_q     <= 1'b1;
            fault_bit_q <= low_idx;
            fault_val_q <= bus.test_in[low_idx];
          end else if (last_pat) begin
            done_q <= 1'b1;
`ifdef STUCK_BIST_CONT_EN
            // Wrap straight into the next sweep; busy stays high.
            p_q        <= '0;
            cnt_q      <= '0;
            test_out_q <= pat_nxt;
`else
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            test_out_q <= '0;
`endif
          end else begin
            p_q        <= p_q + PW'(1);
            cnt_q      <= '0;
            test_out_q <= pat_nxt;
          end
        end
        ST_FAIL: begin
          if (bus.start) begin
            state_q     <= ST_RUN;
            p_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            test_out_q  <= pat_nxt;
            fault_q     <= 1'b0;
            fault_bit_q <= '0;
            fault_val_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          test_out_q <= '0;
        end
      endcase
    end
  end

  assign bus.test_out  = test_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.fault_bit = fault_bit_q;
  assign bus.fault_val = fault_val_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_stuck_at_bist.sv
// Directed bench for stuck_at_bist (WIDTH=8, SETTLE=2). The CUT is a wire
// with per-bit force-to-0 / force-to-1 masks. Expected patterns are queued
// when a run is started and popped each time test_out changes while busy.
import stuck_bist_pkg::*;

module tb_stuck_at_bist;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] f0 = '0;
  logic [W-1:0] f1 = '0;
  state_e dbg_state;

  stuck_at_bist_if #(.WIDTH(W)) bus ();

  stuck_at_bist #(.WIDTH(W), .SETTLE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  assign bus.test_in = (bus.test_out & ~f0) | f1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         mon_first = 1'b1;
  logic [W-1:0] mon_last = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_pat(input int p);
    logic [W-1:0] one;
    one = W'(1);
    if (p == 0)          return '0;
    else if (p == 1)     return '1;
    else if (p < W + 2)  return one << (p - 2);
    else                 return ~(one << (p - W - 2));
  endfunction

  task automatic push_sweep();
    for (int p = 0; p < npat(W); p++) exp_q.push_back(model_pat(p));
  endtask

  // Patterns change every hold window; consecutive patterns always differ.
  always @(negedge clk) begin
    if (mon_en && bus.busy) begin
      if (mon_first || bus.test_out !== mon_last) begin
        if (exp_q.size() == 0) check("pat_overrun_q_size", exp_q.size(), 1);
        else check("pattern", bus.test_out, exp_q.pop_front());
      end
      mon_last  = bus.test_out;
      mon_first = 1'b0;
    end else begin
      mon_first = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the start edge E0.
  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen (bounded by max).
  task automatic wait_done(input int max, output int n, output int busy_hi);
    n = 0;
    busy_hi = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (bus.busy) busy_hi++;
    end while (!bus.done && n < max);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},     dbg_state, ST_IDLE);
    check({tag, "_test_out"},  bus.test_out, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_fault"},     bus.fault, 0);
    check({tag, "_fault_bit"}, bus.fault_bit, 0);
    check({tag, "_fault_val"}, bus.fault_val, 0);
  endtask

  task automatic pass_run(input string tag);
    int n, bh;
    exp_q.delete();
    push_sweep();
    mon_en = 1'b1;
    do_start();
    check({tag, "_busy_e0"}, bus.busy, 1);
    check({tag, "_fault_e0"}, bus.fault, 0);
    wait_done(200, n, bh);
    check({tag, "_done_edge"}, n, 54);
    check({tag, "_busy_cycles"}, bh + 1, 54);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_fault"}, bus.fault, 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, bus.done, 0);
    mon_en = 1'b0;
  endtask

  task automatic fail_run(input string tag, input int exp_n, input int exp_bit, input int exp_val);
    int n, bh;
    do_start();
    check({tag, "_fault_cleared"}, bus.fault, 0);
    wait_done(200, n, bh);
    check({tag, "_detect_edge"}, n, exp_n);
    check({tag, "_fault"}, bus.fault, 1);
    check({tag, "_fault_bit"}, bus.fault_bit, exp_bit);
    check({tag, "_fault_val"}, bus.fault_val, exp_val);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_test_out"}, bus.test_out, 0);
    check({tag, "_state"}, dbg_state, ST_FAIL);
    @(posedge clk); #1;
    check({tag, "_done_width"}, bus.done, 0);
    check({tag, "_fault_sticky"}, bus.fault, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.start = 1'b0;
    #12;
    check_reset_vals("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("after_reset");

`ifndef STUCK_BIST_CONT_EN
    pass_run("pass1");

    f0 = 8'h08;
    fail_run("sa0_bit3", 6, 3, 0);

    f0 = '0; f1 = 8'h20;
    fail_run("sa1_bit5", 3, 5, 1);

    f1 = 8'h44;
    fail_run("sa1_bits6_2", 3, 2, 1);

    f1 = '0;
    pass_run("pass_after_fail");

    // asynchronous abort mid-run
    do_start();
    repeat (20) @(posedge clk);
    #2;
    check("midrun_busy", bus.busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("async_abort");
    @(negedge clk);
    rst = 1'b0;
    pass_run("pass_after_abort");
`else
    begin
      int n, bh, drops;
      drops = 0;
      do_start();
      for (int s = 0; s < 2; s++) begin
        n = 0;
        do begin
          @(posedge clk);
          n++;
          #1;
          if (!bus.busy) drops++;
        end while (!bus.done && n < 200);
        check("cont_done_period", n, 54);
      end
      check("cont_busy_drops", drops, 0);
      f1 = 8'h01;
      wait_done(200, n, bh);
      check("cont_detect_edge", n, 3);
      check("cont_fault", bus.fault, 1);
      check("cont_fault_bit", bus.fault_bit, 0);
      check("cont_fault_val", bus.fault_val, 1);
      check("cont_busy", bus.busy, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stuck_at_bist.md
# stuck_at_bist

- Built-in self-test engine that drives a fixed pattern sequence onto a circuit-under-test (CUT) bus and compares the CUT read-back.
- On the first mismatch it reports which bit is stuck, and whether it is stuck-at-0 or stuck-at-1.
- Sits directly upstream of the `ticker` RGB status block: its `fault` output drives `ticker.fault`.

## Interface
- `WIDTH`, default 8: CUT bus width, ≥2.
- `SETTLE`, default 2: extra cycles each pattern is held before comparison, ≥1.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start` input 1: begin a test run; sampled on the rising edge; ignored while `busy`=1.
- `test_out` output WIDTH: pattern driven to the CUT; registered.
- `test_in` input WIDTH: CUT read-back; assumed already synchronous to `clk`.
- `busy` output 1: high while a run is in progress.
- `done` output 1: one-cycle pulse when a run ends, whether it passed or failed.
- `fault` output 1: sticky stuck-at flag; feeds `ticker.fault`.
- `fault_bit` output $clog2(WIDTH): lowest failing bit index.
- `fault_val` output 1: stuck polarity. 0 means stuck-at-0, 1 means stuck-at-1. Equals `test_in[fault_bit]` at the time of detection.

## Operation
- Pattern sequence (index p, `NPAT` = 2+2·WIDTH patterns):
  - p=0: all-zeros.
  - p=1: all-ones.
  - p=2..WIDTH+1: walking-1, bit p-2 set.
  - p=WIDTH+2..2·WIDTH+1: walking-0, bit p-WIDTH-2 clear.
- FSM states:
  - IDLE:
    - `test_out`=0, `busy`=0.
    - `start`=1 → RUN with p=0, settle counter=0.
  - RUN:
    - `busy`=1; `test_out`=pattern(p).
    - On each edge: if counter<SETTLE, increment it. Otherwise compare `test_in` against `test_out`:
      - Any mismatch → FAIL.
      - Else, if p=NPAT-1 → end of sweep.
      - Else p++, counter=0.
  - End of sweep:
    - Pulse `done`.
    - Go to IDLE (see Configuration).
  - FAIL:
    - `busy`=0, `test_out`=0.
    - `fault`=1, `fault_bit`=lowest mismatching index, `fault_val`=`test_in` at that bit. All captured on the detecting edge.
    - `done` pulses once on entry.
    - `start`=1 → clear `fault`/`fault_bit`/`fault_val` and enter RUN at p=0.
- Multiple stuck bits: only the lowest index among the first failing pattern is reported.
- `start` asserted during RUN is ignored; there is no queuing.
- `fault` is never cleared by a passing run. Only `start` from FAIL, or `rst`, clears it.

## Timing
- Reset values: state=IDLE, `test_out`=0, `busy`=0, `done`=0, `fault`=0, `fault_bit`=0, `fault_val`=0, p=0, counter=0.
- `rst` asserted mid-run aborts immediately and asynchronously; all outputs return to their reset values.
- Start edge E0 → `test_out`=pattern(0) and `busy`=1 from the cycle after E0.
- Each pattern is held SETTLE+1 cycles. The compare of pattern p happens at edge E0+(p+1)(SETTLE+1).
- Full pass:
  - `done` is high in the cycle after edge E0+NPAT·(SETTLE+1).
  - `busy` falls in that same cycle.
  - With WIDTH=8 and SETTLE=2, that is edge E0+54.
- Fail: `fault`, `done`=1 and `busy`=0 are all visible in the cycle after the detecting edge.
- `done` is exactly one cycle wide.

## Configuration
- `STUCK_BIST_CONT_EN` defined (continuous monitoring):
  - End of sweep pulses `done` and immediately re-enters RUN at p=0, counter=0.
  - `busy` stays 1 across the sweep boundary, and pattern(0) is driven in the cycle after the last compare.
  - Only FAIL or `rst` stops the engine.
- Not defined: end of sweep → IDLE; one run per `start`.

## Structure
- Shared package `stuck_bist_pkg` holds:
  - The state enum (IDLE, RUN, FAIL).
  - The function computing `NPAT` from WIDTH.
  - The pattern-class boundary constants.
- Sub-module `stuck_bist_patgen`: combinational index→pattern generator, parameterised by WIDTH.
- The top level contains the FSM, the settle counter, the compare logic and the lowest-set-bit priority encoder.

## Test plan
All scenarios use WIDTH=8, SETTLE=2, with the CUT modelled as a wire (`test_in`=`test_out`) plus optional force-per-bit.

- Fault-free, pulse `start` → `done` pulses at E0+54, `fault`=0, `busy` high for 54 cycles, and all 18 patterns are seen in order on `test_out`.
- Bit 3 forced to 0 → detected at E0+6 (all-ones pattern); `fault`=1, `fault_bit`=3, `fault_val`=0; `test_out` returns to 0.
- Bit 5 forced to 1 → detected at E0+3; `fault_bit`=5, `fault_val`=1.
- Bits 6 and 2 both forced to 1 → `fault_bit`=2 reported; then remove the forces and pulse `start` → `fault` clears on the start edge and the run passes at +54.
- `rst` pulsed at E0+20 mid-run → all outputs take their reset values immediately; a later `start` gives a clean pass.
- Build with `STUCK_BIST_CONT_EN`, fault-free → `done` pulses every 54 cycles and `busy` never falls; force bit 0 to 1 → FAIL at the next p=0 compare.
